// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 74181-style ALU. It processes SLICE bits per clock,
// starting with the LSB slice, and keeps a registered ripple carry between
// slices. The control unit runs it through a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic             saryt,
    input  logic             p16_,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] ac,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             carry_,
    output logic             zsum_,
    output logic             j$,
    output logic             ovf
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             ar_q, ar_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             carry_n_q, carry_n_d, zsum_n_q, zsum_n_d;
    logic             j_q, j_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] u_w, v_w;
    logic [SLICE-1:0] u_sl, v_sl, res_sl;
    logic [SLICE:0]   sum_sl;
    logic             last, cin_msb;
    int unsigned      base;

    // Word-level U/V terms from the latched operands, then the active slice
    always_comb begin
        u_w     = a_q | (b_q & {WIDTH{s_q[0]}}) | (~b_q & {WIDTH{s_q[1]}});
        v_w     = (a_q & b_q & {WIDTH{s_q[3]}}) | (a_q & ~b_q & {WIDTH{s_q[2]}});
        base    = int'(k_q) * SLICE;
        u_sl    = u_w[base +: SLICE];
        v_sl    = v_w[base +: SLICE];
        sum_sl  = {1'b0, u_sl} + {1'b0, v_sl} + {{SLICE{1'b0}}, cy_q};
        res_sl  = ar_q ? sum_sl[SLICE-1:0] : ~(u_sl ^ v_sl);
        // Recover the carry into the MSB from the sum bit: c = s ^ u ^ v
        cin_msb = sum_sl[SLICE-1] ^ u_sl[SLICE-1] ^ v_sl[SLICE-1];
        last    = (k_q == KW'(N - 1));
    end

    // Next-state logic for the IDLE/RUN sequencer and all registered outputs
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cy_d      = cy_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        ar_d      = ar_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        f_d       = f_q;
        carry_n_d = carry_n_q;
        zsum_n_d  = zsum_n_q;
        j_d       = j_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = ac;
                    s_d     = s;
                    ar_d    = saryt;
                    cy_d    = ~p16_;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                f_d[base +: SLICE] = res_sl;
                cy_d = sum_sl[SLICE];
                k_d  = k_q + 1'b1;
                if (last) begin
                    state_d   = IDLE;
                    k_d       = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    zsum_n_d  = |f_d;
                    j_d       = &f_d;
                    carry_n_d = ar_q ? ~sum_sl[SLICE] : 1'b1;
                    ovf_d     = ar_q ? (cin_msb ^ sum_sl[SLICE]) : 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts any running op
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cy_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            ar_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            f_q       <= '0;
            carry_n_q <= 1'b1;
            zsum_n_q  <= 1'b0;
            j_q       <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cy_q      <= cy_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            ar_q      <= ar_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            f_q       <= f_d;
            carry_n_q <= carry_n_d;
            zsum_n_q  <= zsum_n_d;
            j_q       <= j_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign f      = f_q;
    assign carry_ = carry_n_q;
    assign zsum_  = zsum_n_q;
    assign j$     = j_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (16/4, 32/8, 16/16) driven by directed
// vectors and random sweeps, checked against a word-level arithmetic model.
module tb_alu_seq;
    typedef struct packed {
        logic [63:0] f;
        logic        cn;
        logic        zn;
        logic        j;
        logic        ov;
    } res_t;

    localparam res_t RST = '{f: 64'd0, cn: 1'b1, zn: 1'b0, j: 1'b0, ov: 1'b0};

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic [3:0]  s_in = '0;
    logic        ar_in = 1'b0, p_in = 1'b1;
    logic [63:0] a_in = '0, b_in = '0;

    logic [2:0]  busy_v, done_v, cn_v, zn_v, j_v, ov_v;
    logic [15:0] f0, f2;
    logic [31:0] f1;
    logic [63:0] fw [3];
    assign fw[0] = {48'd0, f0};
    assign fw[1] = {32'd0, f1};
    assign fw[2] = {48'd0, f2};

    alu_seq #(.WIDTH(16), .SLICE(4)) u0 (
        .clk_sys(clk_sys), .rst(rst), .start(start[0]), .s(s_in), .saryt(ar_in), .p16_(p_in),
        .a(a_in[15:0]), .ac(b_in[15:0]), .busy(busy_v[0]), .done(done_v[0]), .f(f0),
        .carry_(cn_v[0]), .zsum_(zn_v[0]), .j$(j_v[0]), .ovf(ov_v[0]));
    alu_seq #(.WIDTH(32), .SLICE(8)) u1 (
        .clk_sys(clk_sys), .rst(rst), .start(start[1]), .s(s_in), .saryt(ar_in), .p16_(p_in),
        .a(a_in[31:0]), .ac(b_in[31:0]), .busy(busy_v[1]), .done(done_v[1]), .f(f1),
        .carry_(cn_v[1]), .zsum_(zn_v[1]), .j$(j_v[1]), .ovf(ov_v[1]));
    alu_seq #(.WIDTH(16), .SLICE(16)) u2 (
        .clk_sys(clk_sys), .rst(rst), .start(start[2]), .s(s_in), .saryt(ar_in), .p16_(p_in),
        .a(a_in[15:0]), .ac(b_in[15:0]), .busy(busy_v[2]), .done(done_v[2]), .f(f2),
        .carry_(cn_v[2]), .zsum_(zn_v[2]), .j$(j_v[2]), .ovf(ov_v[2]));

    function automatic int wid(int i);
        return (i == 1) ? 32 : 16;
    endfunction
    function automatic int nsl(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    // Word-level reference: U/V from the function table, then plain addition
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b,
                                   logic [3:0] s, logic ar, logic p);
        logic [63:0] mask, u, v, fv;
        logic [64:0] sum;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        u = (a | (b & {64{s[0]}}) | (~b & {64{s[1]}})) & mask;
        v = ((a & b & {64{s[3]}}) | (a & ~b & {64{s[2]}})) & mask;
        if (ar) begin
            sum  = {1'b0, u} + {1'b0, v} + 65'(!p);
            fv   = sum[63:0] & mask;
            r.cn = !sum[w];
            r.ov = (u[w-1] == v[w-1]) && (fv[w-1] != u[w-1]);
        end else begin
            fv   = ~(u ^ v) & mask;
            r.cn = 1'b1;
            r.ov = 1'b0;
        end
        r.f  = fv;
        r.zn = (fv != 64'd0);
        r.j  = (fv == mask);
        return r;
    endfunction

    int   cyc = 0;
    int   checks = 0, failures = 0;
    int   issued [3] = '{0, 0, 0};
    int   retired [3] = '{0, 0, 0};
    int   due [3];
    res_t expv [3], litv [3], held [3];
    bit   lit_on [3];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(string name, logic [67:0] act, logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Single compare process: done timing and results while an op is in
    // flight, held outputs (and reset values) while idle
    always @(negedge clk_sys) begin
        for (int i = 0; i < 3; i++) begin
            res_t d;
            d = '{f: fw[i], cn: cn_v[i], zn: zn_v[i], j: j_v[i], ov: ov_v[i]};
            if (rst) begin
                held[i]    = RST;
                retired[i] = issued[i];
            end
            if (issued[i] != retired[i]) begin
                if (done_v[i]) begin
                    chk($sformatf("latency%0d", i), 68'(cyc), 68'(due[i]));
                    chk($sformatf("model%0d", i), d, expv[i]);
                    if (lit_on[i]) chk($sformatf("literal%0d", i), d, litv[i]);
                    held[i]    = expv[i];
                    retired[i] = issued[i];
                end else if (cyc >= due[i]) begin
                    checks++;
                    failures++;
                    $display("FAIL nodone%0d actual=no_done expected=done_at_cyc_%0d", i, due[i]);
                    held[i]    = expv[i];
                    retired[i] = issued[i];
                end
            end else begin
                chk($sformatf("idle_done%0d", i), 68'(done_v[i]), 68'd0);
                chk($sformatf("idle_busy%0d", i), 68'(busy_v[i]), 68'd0);
                chk($sformatf("hold%0d", i), d, held[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic issue(int i, logic [63:0] a, logic [63:0] b, logic [3:0] s,
                         logic ar, logic p, bit lo, res_t lit);
        a_in = a; b_in = b; s_in = s; ar_in = ar; p_in = p;
        start[i]  = 1'b1;
        expv[i]   = model(wid(i), a, b, s, ar, p);
        litv[i]   = lit;
        lit_on[i] = lo;
        due[i]    = cyc + 1 + nsl(i);
        issued[i] = issued[i] + 1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(int i);
        for (int t = 0; t < 40 && issued[i] != retired[i]; t++) tick();
    endtask

    task automatic run(int i, logic [63:0] a, logic [63:0] b, logic [3:0] s,
                       logic ar, logic p, bit lo, res_t lit);
        issue(i, a, b, s, ar, p, lo, lit);
        wait_done(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        // Directed vectors with literal expectations
        run(0, 64'hFFFF, 64'h0001, 4'b1001, 1, 1, 1, '{64'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        run(0, 64'h0005, 64'h0003, 4'b0110, 1, 0, 1, '{64'h0002, 1'b0, 1'b1, 1'b0, 1'b0});
        run(0, 64'h8000, 64'h0001, 4'b0110, 1, 0, 1, '{64'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1});
        run(0, 64'h0000, 64'h1234, 4'b1111, 1, 1, 1, '{64'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0});
        run(0, 64'hF0F0, 64'hFF00, 4'b0110, 0, 0, 1, '{64'h0FF0, 1'b1, 1'b1, 1'b0, 1'b0});
        run(0, 64'h4001, 64'h5555, 4'b1100, 1, 1, 1, '{64'h8002, 1'b1, 1'b1, 1'b0, 1'b1});
        run(0, 64'h1234, 64'h0F0F, 4'b0000, 0, 1, 1, '{64'hEDCB, 1'b1, 1'b1, 1'b0, 1'b0});
        run(0, 64'h0000, 64'hFFFF, 4'b1111, 0, 0, 1, '{64'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        run(1, 64'hFFFF_FFFF, 64'h1, 4'b1001, 1, 1, 1, '{64'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        run(2, 64'h7FFF, 64'h0001, 4'b1001, 1, 1, 1, '{64'h8000, 1'b1, 1'b1, 1'b0, 1'b1});

        // Inputs churn and start re-pulses while busy; then back-to-back start
        issue(0, 64'h1234, 64'h1111, 4'b1001, 1, 1, 1, '{64'h2345, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            s_in = 4'($urandom_range(0, 15)); ar_in = 1'($urandom); p_in = 1'($urandom);
            start[0] = 1'b1;
            tick();
        end
        start[0] = 1'b0;
        wait_done(0);
        run(0, 64'h00FF, 64'h0F0F, 4'b0110, 0, 0, 1, '{64'h0FF0, 1'b1, 1'b1, 1'b0, 1'b0});

        // Reset in the second RUN cycle aborts; rst+start drops the start
        issue(0, 64'hABCD, 64'h1111, 4'b1001, 1, 1, 0, RST);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        rst = 1'b1; start[0] = 1'b1;
        tick();
        rst = 1'b0; start[0] = 1'b0;
        repeat (6) tick();
        run(0, 64'hABCD, 64'h1111, 4'b1001, 1, 1, 1, '{64'hBCDE, 1'b1, 1'b1, 1'b0, 1'b0});

        // Random sweeps against the model
        for (int n = 0; n < 1000; n++)
            run(1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 0, RST);
        for (int n = 0; n < 1000; n++)
            run(2, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 0, RST);
        for (int n = 0; n < 200; n++)
            run(0, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 0, RST);
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
